// File: rtl/core_pkg.sv
// Shared types for the MEM stage: controller state encoding and MemtoReg select values.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts ACCESS cycles; expire is high on the last cycle allowed before abort.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: decodes ld/st, runs one req/ack bus access at a time, stalls the front
// of the pipe meanwhile and registers the MEM/WB fields.
module mem_stage_ctrl
    import core_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_mem_wr_data,
    input  logic [4:0]        i_write_reg,
    input  logic              i_reg_write,
    input  logic [1:0]        i_mem_to_reg,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    mem_stage_ctrl_if.master  mem,
    output logic              stall,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_read_data,
    output logic [4:0]        o_write_reg,
    output logic              o_reg_write,
    output logic [1:0]        o_mem_to_reg,
    output logic              align_err,
    output logic              bus_err
);
    state_e            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W-1:0] o_alu_result_q, o_alu_result_d, o_read_data_q, o_read_data_d;
    logic [4:0]        o_write_reg_q, o_write_reg_d;
    logic              o_reg_write_q, o_reg_write_d;
    logic [1:0]        o_mem_to_reg_q, o_mem_to_reg_d;
    logic              align_err_q, align_err_d, bus_err_q, bus_err_d;
    logic              access, misal, stall_c, ctr_clear, ctr_en, expire;

    assign access = i_mem_read | i_mem_write;
    assign misal  = access & (i_alu_result[1:0] != 2'b00);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clear),
        .enable (ctr_en),
        .expire (expire)
    );

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        err_d          = err_q;
        o_alu_result_d = o_alu_result_q;
        o_read_data_d  = o_read_data_q;
        o_write_reg_d  = o_write_reg_q;
        o_reg_write_d  = o_reg_write_q;
        o_mem_to_reg_d = o_mem_to_reg_q;
        align_err_d    = 1'b0;
        bus_err_d      = 1'b0;
        ctr_clear      = 1'b0;
        ctr_en         = 1'b0;
        stall_c        = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misal) begin
                    // Simultaneous read+write is issued as a write.
                    stall_c       = 1'b1;
                    req_d         = 1'b1;
                    we_d          = i_mem_write;
                    addr_d        = {i_alu_result[DATA_W-1:2], 2'b00};
                    wdata_d       = i_mem_wr_data;
                    ctr_clear     = 1'b1;
                    o_reg_write_d = 1'b0;
                    state_d       = ACCESS;
                end else begin
                    o_alu_result_d = i_alu_result;
                    o_write_reg_d  = i_write_reg;
                    o_mem_to_reg_d = i_mem_to_reg;
                    o_reg_write_d  = i_reg_write & ~misal;
                    align_err_d    = misal;
                end
            end
            ACCESS: begin
                stall_c       = 1'b1;
                o_reg_write_d = 1'b0;
                if (mem.mem_ack) begin
                    if (!we_q)
                        rdata_d = mem.mem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (expire) begin
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            DONE: begin
                // EX/MEM still holds the finished op; retire it without reissuing.
                o_alu_result_d = i_alu_result;
                o_write_reg_d  = i_write_reg;
                o_mem_to_reg_d = i_mem_to_reg;
                o_read_data_d  = rdata_q;
                o_reg_write_d  = i_reg_write & ~err_q;
                err_d          = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            o_alu_result_q <= '0;
            o_read_data_q  <= '0;
            o_write_reg_q  <= '0;
            o_reg_write_q  <= 1'b0;
            o_mem_to_reg_q <= '0;
            align_err_q    <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            o_alu_result_q <= o_alu_result_d;
            o_read_data_q  <= o_read_data_d;
            o_write_reg_q  <= o_write_reg_d;
            o_reg_write_q  <= o_reg_write_d;
            o_mem_to_reg_q <= o_mem_to_reg_d;
            align_err_q    <= align_err_d;
            bus_err_q      <= bus_err_d;
        end
    end

    // Reset must silence stall at once, even though EX/MEM may still hold a ld/st.
    assign stall         = stall_c & ~reset;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign o_alu_result  = o_alu_result_q;
    assign o_read_data   = o_read_data_q;
    assign o_write_reg   = o_write_reg_q;
    assign o_reg_write   = o_reg_write_q;
    assign o_mem_to_reg  = o_mem_to_reg_q;
    assign align_err     = align_err_q;
    assign bus_err       = bus_err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl: bench acts as memory and predicts MEM/WB per op.
module tb_mem_stage_ctrl;
    import core_pkg::*;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] i_alu_result, i_mem_wr_data;
    logic [4:0]        i_write_reg;
    logic              i_reg_write, i_mem_read, i_mem_write;
    logic [1:0]        i_mem_to_reg;
    logic              stall, o_reg_write, align_err, bus_err;
    logic [DATA_W-1:0] o_alu_result, o_read_data;
    logic [4:0]        o_write_reg;
    logic [1:0]        o_mem_to_reg;

    mem_stage_ctrl_if #(.DATA_W(DATA_W)) bus ();

    mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_alu_result  (i_alu_result),
        .i_mem_wr_data (i_mem_wr_data),
        .i_write_reg   (i_write_reg),
        .i_reg_write   (i_reg_write),
        .i_mem_to_reg  (i_mem_to_reg),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .mem           (bus),
        .stall         (stall),
        .o_alu_result  (o_alu_result),
        .o_read_data   (o_read_data),
        .o_write_reg   (o_write_reg),
        .o_reg_write   (o_reg_write),
        .o_mem_to_reg  (o_mem_to_reg),
        .align_err     (align_err),
        .bus_err       (bus_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected MEM/WB contents
    logic [31:0] e_alu, e_rdata;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [1:0]  e_mtr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".alu"},   o_alu_result, e_alu);
        chk({tag, ".rdata"}, o_read_data, e_rdata);
        chk({tag, ".rd"},    32'(o_write_reg), 32'(e_rd));
        chk({tag, ".rw"},    32'(o_reg_write), 32'(e_rw));
        chk({tag, ".mtr"},   32'(o_mem_to_reg), 32'(e_mtr));
    endtask

    // Called at a negedge; returns at a negedge after the op has retired into MEM/WB.
    // ack_dly: ACCESS cycle (1-based) carrying mem_ack; outside 1..TIMEOUT means no ack.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rdst, input bit rw,
                          input logic [1:0] mtr, input int ack_dly,
                          input logic [31:0] rdv, input bit stray);
        bit acc, mis, tmo, we;
        int nacc;
        i_alu_result = addr; i_mem_wr_data = wd; i_write_reg = rdst;
        i_reg_write = rw; i_mem_to_reg = mtr; i_mem_read = rd; i_mem_write = wr;
        acc = rd | wr;
        mis = acc && (addr[1:0] != 2'b00);
        we  = wr;
        if (!acc || mis) begin
            bus.mem_ack = stray; bus.mem_rdata = $urandom;
            #1;
            chk("idle.stall", 32'(stall), 32'd0);
            chk("idle.req", 32'(bus.mem_req), 32'd0);
            @(negedge clk);
            bus.mem_ack = 1'b0;
            chk("idle.align_err", 32'(align_err), 32'(mis));
            chk("idle.bus_err", 32'(bus_err), 32'd0);
            chk("idle.req2", 32'(bus.mem_req), 32'd0);
            e_alu = addr; e_rd = rdst; e_rw = rw & ~mis; e_mtr = mtr;
            check_out("idle");
        end else begin
            tmo  = !(ack_dly >= 1 && ack_dly <= TIMEOUT);
            nacc = tmo ? TIMEOUT : ack_dly;
            #1;
            chk("req.stall", 32'(stall), 32'd1);
            chk("req.req0", 32'(bus.mem_req), 32'd0);
            e_rw = 1'b0;
            for (int n = 0; n < nacc; n++) begin
                @(negedge clk);
                chk("acc.req", 32'(bus.mem_req), 32'd1);
                chk("acc.we", 32'(bus.mem_we), 32'(we));
                chk("acc.addr", bus.mem_addr, addr);
                chk("acc.wdata", bus.mem_wdata, wd);
                chk("acc.stall", 32'(stall), 32'd1);
                check_out("acc");
                bus.mem_ack   = (n == nacc - 1) && !tmo;
                bus.mem_rdata = (n == nacc - 1) ? rdv : 32'($urandom);
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            chk("done.req", 32'(bus.mem_req), 32'd0);
            chk("done.stall", 32'(stall), 32'd0);
            chk("done.bus_err", 32'(bus_err), 32'(tmo));
            chk("done.align_err", 32'(align_err), 32'd0);
            @(negedge clk);
            chk("post.bus_err", 32'(bus_err), 32'd0);
            e_alu = addr; e_rd = rdst; e_rw = rw & ~tmo; e_mtr = mtr;
            if (!tmo && !we) e_rdata = rdv;
            check_out("post");
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        i_alu_result = '0; i_mem_wr_data = '0; i_write_reg = '0;
        i_reg_write = 1'b0; i_mem_to_reg = '0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        reset = 1'b1;
        e_alu = '0; e_rdata = '0; e_rd = '0; e_rw = 1'b0; e_mtr = '0;
        repeat (2) @(negedge clk);
        chk("rst.req", 32'(bus.mem_req), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        check_out("rst");
        reset = 1'b0;

        // ALU op, load, store, misaligned load, timeout then stray ack
        run_op(0, 0, 32'h10, 32'h0, 5'd5, 1, MTR_ALU, 0, 0, 0);
        run_op(1, 0, 32'h100, 32'h0, 5'd7, 1, MTR_MEM, 3, 32'hDEADBEEF, 0);
        run_op(0, 1, 32'h200, 32'h55, 5'd0, 0, MTR_ALU, 1, 32'h1234, 0);
        run_op(1, 0, 32'h102, 32'h0, 5'd9, 1, MTR_MEM, 1, 32'h0, 0);
        run_op(1, 0, 32'h104, 32'h0, 5'd3, 1, MTR_MEM, 0, 32'h0, 0);
        run_op(0, 0, 32'h44, 32'h0, 5'd4, 1, MTR_PC4, 0, 0, 1);
        // Ack arriving on the last allowed cycle beats the timeout
        run_op(1, 0, 32'h108, 32'h0, 5'd6, 1, MTR_MEM, TIMEOUT, 32'hCAFE0001, 0);
        // Read+write together is a write
        run_op(1, 1, 32'h10C, 32'hA5A5, 5'd8, 0, MTR_ALU, 2, 32'hFFFF, 0);

        // Reset during the second ACCESS cycle
        i_alu_result = 32'h300; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_reg_write = 1'b1; i_write_reg = 5'd11; i_mem_to_reg = MTR_MEM;
        repeat (2) @(negedge clk);
        chk("mid.req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        e_alu = '0; e_rdata = '0; e_rd = '0; e_rw = 1'b0; e_mtr = '0;
        chk("midrst.req", 32'(bus.mem_req), 32'd0);
        chk("midrst.stall", 32'(stall), 32'd0);
        check_out("midrst");
        @(negedge clk);
        i_mem_read = 1'b0; i_reg_write = 1'b0;
        reset = 1'b0;
        run_op(1, 0, 32'h300, 32'h0, 5'd11, 1, MTR_MEM, 2, 32'h0BADF00D, 0);

        for (int k = 0; k < 40; k++) begin
            int kind, r, dly;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            r    = $urandom_range(0, 9);
            dly  = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 5);
            a    = $urandom & 32'hFFFF_FFFC;
            if (kind == 4) a[1:0] = 2'($urandom_range(1, 3));
            run_op(kind == 1 || kind == 3 || kind == 4, kind == 2 || kind == 3, a,
                   $urandom, 5'($urandom), 1'($urandom), 2'($urandom_range(0, 2)),
                   dly, $urandom, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
